// File: rtl/pe_array_ctrl_pkg.sv
// Shared types for the 6x7 PE array controller.
// Array geometry, array-facing enums and controller state encoding.
package pe_array_ctrl_pkg;

  localparam int PE_ROWS = 6;
  localparam int PE_COLS = 7;

  typedef logic [PE_ROWS-1:0][PE_COLS-1:0] pe_flags_t;

  typedef enum logic [1:0] {
    MODE1,
    MODE2,
    MODE3,
    MODE4
  } op_mode_t;

  typedef enum logic [1:0] {
    STG_IDLE,
    STG_LOAD,
    STG_COMPUTE
  } op_stage_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG,
    S_LOAD,
    S_COMPUTE,
    S_NEXT,
    S_FINISH,
    S_FAULT
  } ctrl_state_t;

endpackage

// File: rtl/pe_array_ctrl_mask.sv
// Masked AND-reduce of a PE flag array.
// Unmasked PEs count as set, so an empty mask is always satisfied.
module pe_mask_reduce
  import pe_array_ctrl_pkg::*;
(
  input  pe_flags_t flags,
  input  pe_flags_t mask,
  output logic      all_set
);

  assign all_set = &(flags | ~mask);

endmodule

// File: rtl/pe_array_ctrl.sv
// Job sequencer for the 6x7 PE array: mode load, per-round
// load/compute handshakes, watchdog and sticky fault handling.
module pe_array_ctrl
  import pe_array_ctrl_pkg::*;
#(
  parameter int MAX_ROUNDS  = 255,
  parameter int WDOG_CYCLES = 4096
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      start,
  input  logic      abort,
  input  op_mode_t  mode_cfg,
  input  logic [7:0] num_rounds,
  input  pe_flags_t active_mask,
  input  pe_flags_t pe_full,
  input  pe_flags_t pe_conv_done,
  input  logic      array_error,
  output op_mode_t  mode,
  output logic      change_mode,
  output op_stage_t op_stage,
  output logic      conv_continue,
  output logic [7:0] round_cnt,
  output logic      busy,
  output logic      job_done,
  output logic      err
);

  localparam int WW = $clog2(WDOG_CYCLES + 1);
  localparam logic [WW-1:0] WD_LIM = WW'(WDOG_CYCLES - 1);
  localparam logic [7:0] MAXR = 8'(MAX_ROUNDS);

  ctrl_state_t state, state_n;
  pe_flags_t   mask_q, mask_n;
  logic [7:0]  rounds_q, rounds_n;
  logic [WW-1:0] wdog, wdog_n;

  op_mode_t   mode_n;
  op_stage_t  stage_n;
  logic       chg_n, cont_n, busy_n, done_n, err_n;
  logic [7:0] rcnt_n, rc_inc, req_rounds;
  logic       full_ok, done_ok, wd_hit;

  pe_mask_reduce u_full (
    .flags   (pe_full),
    .mask    (mask_q),
    .all_set (full_ok)
  );

  pe_mask_reduce u_done (
    .flags   (pe_conv_done),
    .mask    (mask_q),
    .all_set (done_ok)
  );

  assign rc_inc = round_cnt + 8'd1;
  assign wd_hit = (wdog == WD_LIM);
  assign req_rounds = (num_rounds == 8'd0) ? 8'd1 :
                      (num_rounds > MAXR)  ? MAXR : num_rounds;

  always_comb begin
    state_n  = state;
    mode_n   = mode;
    mask_n   = mask_q;
    rounds_n = rounds_q;
    rcnt_n   = round_cnt;
    err_n    = err;
    cont_n   = 1'b0;
    if (abort) begin
      state_n = S_IDLE;
    end else if (state != S_IDLE && array_error) begin
      err_n   = 1'b1;
      state_n = S_FAULT;
    end else begin
      unique case (state)
        S_IDLE: if (start) begin
          mode_n   = mode_cfg;
          mask_n   = active_mask;
          rounds_n = req_rounds;
          rcnt_n   = 8'd0;
          err_n    = 1'b0;
          state_n  = S_CFG;
        end
        S_CFG: state_n = S_LOAD;
        S_LOAD: begin
          if (full_ok) state_n = S_COMPUTE;
          else if (wd_hit) begin
            err_n   = 1'b1;
            state_n = S_FAULT;
          end
        end
        S_COMPUTE: begin
          if (done_ok) begin
            rcnt_n  = rc_inc;
            cont_n  = (rc_inc != rounds_q);
            state_n = S_NEXT;
          end else if (wd_hit) begin
            err_n   = 1'b1;
            state_n = S_FAULT;
          end
        end
        S_NEXT:   state_n = (round_cnt == rounds_q) ? S_FINISH : S_LOAD;
        S_FINISH: state_n = S_IDLE;
        S_FAULT:  state_n = S_FAULT;
        default:  state_n = S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they register with it.
  always_comb begin
    chg_n  = (state_n == S_CFG);
    busy_n = (state_n != S_IDLE);
    done_n = (state_n == S_FINISH);
    unique case (1'b1)
      (state_n == S_LOAD): stage_n = STG_LOAD;
      (state_n == S_COMPUTE),
      (state_n == S_NEXT): stage_n = STG_COMPUTE;
      default:             stage_n = STG_IDLE;
    endcase
    if (state_n == state &&
        (state == S_LOAD || state == S_COMPUTE))
      wdog_n = wdog + 1'b1;
    else
      wdog_n = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= S_IDLE;
      mode          <= MODE1;
      mask_q        <= '0;
      rounds_q      <= 8'd1;
      wdog          <= '0;
      op_stage      <= STG_IDLE;
      round_cnt     <= 8'd0;
      change_mode   <= 1'b0;
      conv_continue <= 1'b0;
      busy          <= 1'b0;
      job_done      <= 1'b0;
      err           <= 1'b0;
    end else begin
      state         <= state_n;
      mode          <= mode_n;
      mask_q        <= mask_n;
      rounds_q      <= rounds_n;
      wdog          <= wdog_n;
      op_stage      <= stage_n;
      round_cnt     <= rcnt_n;
      change_mode   <= chg_n;
      conv_continue <= cont_n;
      busy          <= busy_n;
      job_done      <= done_n;
      err           <= err_n;
    end
  end

endmodule

// File: tb/tb_pe_array_ctrl.sv
// Directed bench for pe_array_ctrl.
// Strobes are tallied on the falling edge; checks run 1ns after rise.
module tb_pe_array_ctrl;
  import pe_array_ctrl_pkg::*;

  logic      clk = 1'b0;
  logic      rst;
  logic      start, abort, array_error;
  op_mode_t  mode_cfg;
  logic [7:0] num_rounds;
  pe_flags_t active_mask, pe_full, pe_conv_done;
  op_mode_t  mode;
  op_stage_t op_stage;
  logic      change_mode, conv_continue, busy, job_done, err;
  logic [7:0] round_cnt;

  pe_array_ctrl #(
    .MAX_ROUNDS  (255),
    .WDOG_CYCLES (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .abort         (abort),
    .mode_cfg      (mode_cfg),
    .num_rounds    (num_rounds),
    .active_mask   (active_mask),
    .pe_full       (pe_full),
    .pe_conv_done  (pe_conv_done),
    .array_error   (array_error),
    .mode          (mode),
    .change_mode   (change_mode),
    .op_stage      (op_stage),
    .conv_continue (conv_continue),
    .round_cnt     (round_cnt),
    .busy          (busy),
    .job_done      (job_done),
    .err           (err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_chg   = 0;
  int n_cont  = 0;
  int n_done  = 0;
  int n_both  = 0;

  always @(negedge clk) begin
    if (change_mode) n_chg++;
    if (conv_continue) n_cont++;
    if (job_done) n_done++;
    if (change_mode && conv_continue) n_both++;
  end

  pe_flags_t all1, only56;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_stage(input op_stage_t s);
    int n;
    n = 0;
    while (op_stage != s && n < 200) begin
      step();
      n++;
    end
    if (op_stage != s) chk("wait_stage", int'(op_stage), int'(s));
  endtask

  task automatic kick(input op_mode_t m, input logic [7:0] r,
                      input pe_flags_t msk);
    mode_cfg    = m;
    num_rounds  = r;
    active_mask = msk;
    start       = 1'b1;
    step();
    start       = 1'b0;
  endtask

  task automatic run_round();
    wait_stage(STG_LOAD);
    repeat (5) step();
    chk("load_wait", int'(op_stage), int'(STG_LOAD));
    pe_full = all1;
    wait_stage(STG_COMPUTE);
    pe_full = '0;
    repeat (10) step();
    chk("comp_wait", int'(op_stage), int'(STG_COMPUTE));
    pe_conv_done = all1;
    step();
    pe_conv_done = '0;
  endtask

  int b_chg, b_cont, b_done, lat;

  initial begin
    all1   = '1;
    only56 = '0;
    only56[5][6] = 1'b1;
    rst = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    array_error = 1'b0;
    mode_cfg = MODE1;
    num_rounds = 8'd0;
    active_mask = '0;
    pe_full = '0;
    pe_conv_done = '0;
    repeat (3) step();
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_stage", int'(op_stage), int'(STG_IDLE));
    chk("rst_mode", int'(mode), int'(MODE1));
    chk("rst_rcnt", int'(round_cnt), 0);
    chk("rst_done", int'(job_done), 0);
    rst = 1'b1;
    step();

    // three rounds, MODE2, full mask
    b_chg = n_chg; b_cont = n_cont; b_done = n_done;
    kick(MODE2, 8'd3, all1);
    chk("cfg_chg", int'(change_mode), 1);
    chk("cfg_mode", int'(mode), int'(MODE2));
    chk("cfg_busy", int'(busy), 1);
    repeat (3) run_round();
    chk("r3_cnt", int'(round_cnt), 3);
    chk("r3_cont", int'(conv_continue), 0);
    step();
    chk("r3_jdone", int'(job_done), 1);
    step();
    chk("r3_idle", int'(busy), 0);
    chk("r3_hold", int'(round_cnt), 3);
    chk("r3_nchg", n_chg - b_chg, 1);
    chk("r3_ncont", n_cont - b_cont, 2);
    chk("r3_ndone", n_done - b_done, 1);

    // num_rounds = 0 behaves as one round
    b_cont = n_cont; b_done = n_done;
    kick(MODE3, 8'd0, all1);
    run_round();
    chk("z_cnt", int'(round_cnt), 1);
    step();
    chk("z_jdone", int'(job_done), 1);
    step();
    chk("z_ncont", n_cont - b_cont, 0);
    chk("z_ndone", n_done - b_done, 1);

    // single-PE mask at [5][6]
    kick(MODE1, 8'd1, only56);
    wait_stage(STG_LOAD);
    pe_full = only56;
    step();
    chk("m_load", int'(op_stage), int'(STG_COMPUTE));
    pe_full = '0;
    repeat (3) step();
    chk("m_hold", int'(op_stage), int'(STG_COMPUTE));
    chk("m_hcnt", int'(round_cnt), 0);
    pe_conv_done = only56;
    step();
    pe_conv_done = '0;
    chk("m_cnt", int'(round_cnt), 1);
    step();
    chk("m_jdone", int'(job_done), 1);
    step();

    // array_error in COMPUTE, then abort
    b_done = n_done;
    kick(MODE4, 8'd2, all1);
    wait_stage(STG_LOAD);
    pe_full = all1;
    wait_stage(STG_COMPUTE);
    pe_full = '0;
    array_error = 1'b1;
    step();
    array_error = 1'b0;
    chk("f_err", int'(err), 1);
    chk("f_stage", int'(op_stage), int'(STG_IDLE));
    repeat (4) step();
    chk("f_busy", int'(busy), 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("a_busy", int'(busy), 0);
    chk("a_err", int'(err), 1);
    repeat (3) step();
    chk("a_sticky", int'(err), 1);
    chk("a_ndone", n_done - b_done, 0);
    kick(MODE1, 8'd1, all1);
    chk("s_clr", int'(err), 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("s_abort", int'(busy), 0);

    // watchdog: pe_full never set
    kick(MODE1, 8'd1, all1);
    wait_stage(STG_LOAD);
    lat = 0;
    while (err == 1'b0 && lat < 40) begin
      step();
      lat++;
    end
    chk("wd_lat", lat, 16);
    chk("wd_busy", int'(busy), 1);
    chk("wd_stage", int'(op_stage), int'(STG_IDLE));
    abort = 1'b1;
    step();
    abort = 1'b0;

    // reset during round 2, start ignored mid-job
    kick(MODE3, 8'd3, all1);
    run_round();
    wait_stage(STG_LOAD);
    b_chg = n_chg;
    mode_cfg = MODE4;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("ig_mode", int'(mode), int'(MODE3));
    chk("ig_nchg", n_chg - b_chg, 0);
    pe_full = all1;
    wait_stage(STG_COMPUTE);
    pe_full = '0;
    b_done = n_done;
    rst = 1'b0;
    step();
    chk("mr_busy", int'(busy), 0);
    chk("mr_stage", int'(op_stage), int'(STG_IDLE));
    chk("mr_rcnt", int'(round_cnt), 0);
    chk("mr_mode", int'(mode), int'(MODE1));
    chk("mr_err", int'(err), 0);
    rst = 1'b1;
    repeat (4) step();
    chk("mr_ndone", n_done - b_done, 0);
    chk("mr_idle", int'(busy), 0);
    chk("no_both", n_both, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
